// File: rtl/image_sum_accumulator.sv
// image_sum_accumulator: per-pixel running sums and completed-image count for one class.
// Once the class is finished the sums and count are held for the averaging divider.
module image_sum_accumulator #(
    parameter int NUM_PIXELS = 784,
    parameter int PIX_W      = 8,
    parameter int SUM_W      = 24,
    parameter int CNT_W      = 14
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  clear,
    input  logic                                  finish,
    input  logic                                  pixel_valid,
    input  logic [PIX_W-1:0]                      pixel_in,
    output logic                                  in_ready,
    output logic [NUM_PIXELS-1:0][SUM_W-1:0]      sums,
    output logic [CNT_W-1:0]                      num_images,
    output logic                                  done,
    output logic                                  empty
);

    localparam int IDX_W = $clog2(NUM_PIXELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FULL  = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] pix_idx;
    logic             finish_pend;
    logic             accept;
    logic             last_px;

    assign accept  = pixel_valid && in_ready && !clear;
    assign last_px = accept && (pix_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // A finish mid-image is deferred so that only whole images are counted.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ACCUM;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (finish && pix_idx == '0) begin
                        state_nxt = DONE;
                    end else if (last_px && (finish_pend || finish)) begin
                        state_nxt = DONE;
                    end else if (last_px && num_images == CNT_MAX - 1'b1) begin
                        state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (finish) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = ACCUM;
                end
            endcase
        end
    end

    always_comb begin
        in_ready = 1'b0;
        done     = 1'b0;
        empty    = 1'b0;
        unique case (state)
            ACCUM:   in_ready = 1'b1;
            FULL:    in_ready = 1'b0;
            DONE: begin
                done  = 1'b1;
                empty = (num_images == '0);
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Count saturation bounds the sums, so they need no overflow handling.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sums        <= '0;
            num_images  <= '0;
            pix_idx     <= '0;
            finish_pend <= 1'b0;
        end else begin
            if (accept) begin
                sums[pix_idx] <= sums[pix_idx] + SUM_W'(pixel_in);
                pix_idx       <= last_px ? '0 : pix_idx + 1'b1;
                if (last_px && num_images != CNT_MAX) begin
                    num_images <= num_images + 1'b1;
                end
            end
            if (state == ACCUM && finish && pix_idx != '0) begin
                finish_pend <= 1'b1;
            end
        end
    end

endmodule
